// File: rtl/mc_ctrl_rv32i.sv
// Multicycle control FSM for an RV32I datapath: fetch/decode/exec/mem/wb sequencing,
// immediate-type select, datapath enables, and a bounded memory handshake with trap.
module mc_ctrl_rv32i #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [2:0] cu_immtype,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_IDLE   = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R      = 4'd0,
    C_IALU   = 4'd1,
    C_LOAD   = 4'd2,
    C_STORE  = 4'd3,
    C_BRANCH = 4'd4,
    C_LUI    = 4'd5,
    C_AUIPC  = 4'd6,
    C_JAL    = 4'd7,
    C_JALR   = 4'd8,
    C_ILL    = 4'd9
  } cls_t;

  function automatic cls_t decode_class(input logic [6:0] opc);
    case (opc)
      7'b0110011: decode_class = C_R;
      7'b0010011: decode_class = C_IALU;
      7'b0000011: decode_class = C_LOAD;
      7'b0100011: decode_class = C_STORE;
      7'b1100011: decode_class = C_BRANCH;
      7'b0110111: decode_class = C_LUI;
      7'b0010111: decode_class = C_AUIPC;
      7'b1101111: decode_class = C_JAL;
      7'b1100111: decode_class = C_JALR;
      default:    decode_class = C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input cls_t c);
    case (c)
      C_IALU, C_LOAD, C_JALR: imm_of = 3'b000;
      C_STORE:                imm_of = 3'b001;
      C_BRANCH:               imm_of = 3'b010;
      C_LUI, C_AUIPC:         imm_of = 3'b011;
      C_JAL:                  imm_of = 3'b100;
      default:                imm_of = 3'b000;
    endcase
  endfunction

  state_t           state_r, state_s;
  cls_t             cls_r;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             timeout_s;
  logic             in_mem_phase_s;

  assign state          = state_r;
  assign in_mem_phase_s = (state_r == S_FETCH) || (state_r == S_MEM);
  // Ready arriving in the timeout cycle takes priority, hence the !mem_ready term.
  assign timeout_s      = (MEM_TIMEOUT != 0) && (cnt_r == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

  // State, class latch, wait counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cls_r   <= C_R;
      cnt_r   <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (state_r == S_DECODE) begin
        cls_r <= decode_class(opcode);
      end
      if ((state_r == S_DECODE) && (decode_class(opcode) == C_ILL)) begin
        illegal <= 1'b1;
      end
      if (in_mem_phase_s && timeout_s) begin
        bus_err <= 1'b1;
      end
    end
  end

  // Wait counter restarts on any state change or completed handshake.
  always_comb begin
    cnt_s = '0;
    if ((state_s != state_r) || mem_ready) begin
      cnt_s = '0;
    end else if (in_mem_phase_s) begin
      cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_s = '0;
    end
  end

  // Next-state and enable decode.
  always_comb begin
    state_s      = state_r;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    case (state_r)
      S_IDLE: state_s = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_s = S_DECODE;
        end else if (timeout_s) begin
          state_s = S_TRAP;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (decode_class(opcode) == C_ILL) begin
          state_s = S_TRAP;
        end else begin
          state_s = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_r)
          C_BRANCH: begin
            if (br_taken) begin
              pc_we  = 1'b1;
              pc_src = 2'd1;
            end else begin
              pc_we  = 1'b0;
            end
            state_s = S_FETCH;
          end
          C_JAL: begin
            pc_we   = 1'b1;
            pc_src  = 2'd1;
            state_s = S_WB;
          end
          C_JALR: begin
            pc_we   = 1'b1;
            pc_src  = 2'd2;
            state_s = S_WB;
          end
          C_LOAD, C_STORE:              state_s = S_MEM;
          C_R, C_IALU, C_LUI, C_AUIPC:  state_s = S_WB;
          default:                      state_s = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_r == C_STORE);
        if (mem_ready) begin
          state_s = (cls_r == C_STORE) ? S_FETCH : S_WB;
        end else if (timeout_s) begin
          state_s = S_TRAP;
        end else begin
          state_s = S_MEM;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        case (cls_r)
          C_LOAD:        wb_sel = 2'd1;
          C_JAL, C_JALR: wb_sel = 2'd2;
          default:       wb_sel = 2'd0;
        endcase
        state_s = S_FETCH;
      end
      S_TRAP:  state_s = S_TRAP;
      default: state_s = S_TRAP;
    endcase
  end

  // Immediate type and ALU operand/op selects; held through MEM and WB.
  always_comb begin
    cu_immtype = 3'b000;
    alu_src_a  = 2'd0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    case (state_r)
      S_DECODE: cu_immtype = imm_of(decode_class(opcode));
      S_EXEC, S_MEM, S_WB: begin
        cu_immtype = imm_of(cls_r);
        case (cls_r)
          C_R:    alu_op = 2'b10;
          C_IALU: begin
            alu_src_b = 1'b1;
            alu_op    = 2'b10;
          end
          C_LOAD, C_STORE, C_JALR: alu_src_b = 1'b1;
          C_LUI: begin
            alu_src_a = 2'd2;
            alu_src_b = 1'b1;
          end
          C_AUIPC: begin
            alu_src_a = 2'd1;
            alu_src_b = 1'b1;
          end
          C_BRANCH: alu_op = 2'b01;
          default:  alu_op = 2'b00;
        endcase
      end
      default: cu_immtype = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_rv32i.sv
// Directed-vector bench for mc_ctrl_rv32i with immediate-assertion checks.
module tb_mc_ctrl_rv32i;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       br_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, alu_src_b;
  logic [1:0] pc_src, alu_src_a, alu_op, wb_sel;
  logic [2:0] cu_immtype, state;
  logic       illegal, bus_err;

  int vectors = 0;
  int miscompares = 0;

  mc_ctrl_rv32i #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .cu_immtype(cu_immtype), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [4:0]  en_all  = {mem_req, mem_we, ir_we, pc_we, rf_we};
  wire [19:0] out_all = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, cu_immtype,
                         alu_src_a, alu_src_b, alu_op, rf_we, wb_sel, illegal, bus_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: complete the fetch in one cycle and decode opc; ends in EXEC.
  task automatic fetch(input logic [6:0] opc);
    mem_ready = 1'b1;
    #1;
    chk("fetch_state", 32'(state), 32'd0);
    chk("fetch_ir_we", 32'(ir_we), 32'd1);
    tick();
    mem_ready = 1'b0;
    opcode = opc;
    #1;
    chk("decode_state", 32'(state), 32'd1);
    tick();
  endtask

  initial begin
    rst_n = 1'b1; opcode = 7'd0; br_taken = 1'b0; mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd5);
    chk("rst_outs", 32'(out_all), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("idle_state", 32'(state), 32'd5);
    chk("idle_en", 32'(en_all), 32'd0);
    tick();

    // R-type: 5,0,1,2,4,0
    fetch(7'b0110011);
    chk("r_exec_state", 32'(state), 32'd2);
    chk("r_exec_op", 32'({alu_src_a, alu_src_b, alu_op}), 32'b00_0_10);
    tick();
    chk("r_wb_state", 32'(state), 32'd4);
    chk("r_wb", 32'({rf_we, wb_sel}), 32'b1_00);
    tick();
    chk("r_back_fetch", 32'(state), 32'd0);

    // LOAD with ready on the 4th MEM cycle
    fetch(7'b0000011);
    chk("ld_exec", 32'({alu_src_a, alu_src_b, alu_op}), 32'b00_1_00);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_state", 32'(state), 32'd3);
      chk("ld_mem_sel", 32'({mem_req, mem_addr_sel, mem_we}), 32'b110);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("ld_mem_last", 32'(state), 32'd3);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("ld_wb_state", 32'(state), 32'd4);
    chk("ld_wb", 32'({rf_we, wb_sel, cu_immtype}), 32'b1_01_000);
    tick();
    chk("ld_back_fetch", 32'(state), 32'd0);

    // BRANCH taken, then not taken
    fetch(7'b1100011);
    br_taken = 1'b1;
    #1;
    chk("bt_exec", 32'({pc_we, pc_src, cu_immtype, alu_op}), 32'b1_01_010_01);
    tick();
    br_taken = 1'b0;
    chk("bt_fetch", 32'(state), 32'd0);
    fetch(7'b1100011);
    chk("bn_exec_pcwe", 32'(pc_we), 32'd0);
    tick();
    chk("bn_fetch", 32'(state), 32'd0);

    // JAL then JALR
    fetch(7'b1101111);
    chk("jal_exec", 32'({pc_we, pc_src, cu_immtype}), 32'b1_01_100);
    tick();
    chk("jal_wb", 32'({state, rf_we, wb_sel}), 32'b100_1_10);
    tick();
    fetch(7'b1100111);
    chk("jalr_exec", 32'({pc_we, pc_src, cu_immtype, alu_src_b}), 32'b1_10_000_1);
    tick();
    chk("jalr_wb", 32'({state, rf_we, wb_sel}), 32'b100_1_10);
    tick();

    // LUI and AUIPC operand selects
    fetch(7'b0110111);
    chk("lui_exec", 32'({alu_src_a, alu_src_b, alu_op, cu_immtype}), 32'b10_1_00_011);
    tick(); tick();
    fetch(7'b0010111);
    chk("auipc_exec", 32'({alu_src_a, alu_src_b, alu_op, cu_immtype}), 32'b01_1_00_011);
    tick(); tick();

    // STORE: 4 cycles with ready-in-1
    fetch(7'b0100011);
    chk("st_exec_imm", 32'(cu_immtype), 32'b001);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("st_mem", 32'({state, mem_req, mem_we, mem_addr_sel}), 32'b011_111);
    tick();
    mem_ready = 1'b0;
    chk("st_back_fetch", 32'(state), 32'd0);

    // Ready arriving on the 16th FETCH wait cycle: no error
    for (int i = 0; i < 15; i++) begin
      chk("late_fetch_wait", 32'({state, mem_req}), 32'b000_1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("late_fetch_ok", 32'({state, bus_err, ir_we}), 32'b000_0_1);
    tick();
    mem_ready = 1'b0;
    opcode = 7'b0010011;
    #1;
    chk("late_decode", 32'({state, bus_err}), 32'b001_0);
    tick();
    chk("ialu_exec", 32'({alu_src_a, alu_src_b, alu_op}), 32'b00_1_10);
    tick(); tick();

    // Reset mid-MEM
    fetch(7'b0000011);
    tick();
    chk("pre_rst_mem", 32'(state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state), 32'd5);
    chk("midrst_outs", 32'(out_all), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Illegal opcode (SYSTEM)
    fetch(7'b1110011);
    chk("ill_state", 32'(state), 32'd7);
    chk("ill_flag", 32'(illegal), 32'd1);
    for (int i = 0; i < 3; i++) begin
      mem_ready = i[0];
      #1;
      chk("ill_hold", 32'({state, en_all, illegal}), {24'd0, 3'd7, 5'd0, 1'b1} >> 0);
      tick();
    end
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ill_rst_clear", 32'({state, illegal}), 32'b101_0);
    tick();
    rst_n = 1'b1;
    tick();

    // FETCH timeout
    for (int i = 0; i < 16; i++) begin
      chk("to_fetch_wait", 32'({state, mem_req, bus_err}), 32'b000_1_0);
      tick();
    end
    chk("to_trap", 32'({state, bus_err, mem_req, illegal}), 32'b111_1_0_0);
    tick();
    chk("to_trap_hold", 32'({state, en_all, bus_err}), 32'b111_00000_1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
